// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the nibble-serial adder controller.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SLICE_W = 4;

    // Minimum 1 bit so a two-step counter still has a usable width.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_slice.sv
// Combinational 4-bit adder slice; carry out is bit 4 of a 5-bit sum.
module adder_slice4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] sum,
    output logic       co
);

    logic [4:0] w_sum5;

    assign w_sum5    = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
    assign {co, sum} = w_sum5;

endmodule

// File: rtl/serial_adder_ctrl.sv
// WIDTH-bit adder built from one shared 4-bit slice, one nibble per cycle, LSB nibble first.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' input selecting x - y.
//   state | meaning
//   IDLE  | in_ready=1, waiting for in_valid; operands latched on accept
//   RUN   | one nibble per cycle through the slice, carry registered between nibbles
//   DONE  | out_valid=1, result held until out_ready
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out
);

    localparam int STEPS = WIDTH / SLICE_W;
    localparam int CW    = clog2(STEPS);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_s;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_c_out;

    logic [WIDTH-1:0] w_y_lat;
    logic             w_c_lat;
    logic [3:0]       w_nib_x;
    logic [3:0]       w_nib_y;
    logic [3:0]       w_slice_sum;
    logic             w_slice_co;
    logic             w_last;

`ifdef SERIAL_ADDER_SUB_EN
    // Two's-complement subtract: invert y once at latch time, inject the +1 via the carry.
    assign w_y_lat = sub ? ~y : y;
    assign w_c_lat = c_in ^ sub;
`else
    assign w_y_lat = y;
    assign w_c_lat = c_in;
`endif

    assign w_nib_x = r_x[r_cnt*SLICE_W +: SLICE_W];
    assign w_nib_y = r_y[r_cnt*SLICE_W +: SLICE_W];
    assign w_last  = (r_cnt == CW'(STEPS - 1));

    adder_slice4 u_slice (
        .a   (w_nib_x),
        .b   (w_nib_y),
        .ci  (r_carry),
        .sum (w_slice_sum),
        .co  (w_slice_co)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next = RUN;
            RUN:     if (w_last)    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x     <= '0;
            r_y     <= '0;
            r_s     <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_c_out <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_x     <= x;
                        r_y     <= w_y_lat;
                        r_carry <= w_c_lat;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_s[r_cnt*SLICE_W +: SLICE_W] <= w_slice_sum;
                    r_carry <= w_slice_co;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) r_c_out <= w_slice_co;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign s         = r_s;
    assign c_out     = r_c_out;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: vector table, scoreboard queue, reset corner cases.
module tb_serial_adder_ctrl;

    localparam int W     = 16;
    localparam int STEPS = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         c_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         c_out;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] es;
        logic         ec;
        int           stall;
        bit           disturb;
    } vec_t;

    res_t sb_q[$];
    vec_t vecs[7];

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .c_in      (c_in),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .c_out     (c_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input logic [W-1:0] es, input logic ec,
                          input int stall, input bit disturb);
        int   cyc;
        int   low;
        res_t e;
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            tick();
            cyc++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL ready_timeout: got in_ready=0, want 1 within 20 cycles");
            return;
        end
        out_ready = (stall == 0);
        x         = a;
        y         = b;
        c_in      = ci;
        in_valid  = 1'b1;
        sb_q.push_back(res_t'{s: es, c: ec});
        tick();
        in_valid = 1'b0;
        cyc = 0;
        low = 0;
        while (!out_valid && cyc < 3 * STEPS) begin
            if (!in_ready) low++;
            if (disturb) begin
                x        = W'($urandom);
                y        = W'($urandom);
                c_in     = ~c_in;
                in_valid = 1'b1;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        e = sb_q.pop_front();
        if (!out_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: got out_valid=0, want 1 within %0d cycles", 3 * STEPS);
            return;
        end
        if (!in_ready) low++;
        chk("latency", cyc, STEPS);
        chk("sum", s, e.s);
        chk("c_out", c_out, e.c);
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("stall_valid", out_valid, 1);
            chk("stall_sum", s, e.s);
            chk("stall_c_out", c_out, e.c);
            chk("stall_in_ready", in_ready, 0);
        end
        if (stall == 0) chk("in_ready_low_cycles", low, STEPS + 1);
        out_ready = 1'b1;
        tick();
        chk("idle_in_ready", in_ready, 1);
        chk("idle_out_valid", out_valid, 0);
        if (disturb) begin
            tick();
            chk("no_second_op", {out_valid, in_ready}, 2'b01);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, want completion");
        $fatal(1);
    end

    initial begin
        bit saw_valid;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0,  0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1,  0, 1'b0};
        vecs[2] = '{16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0,  0, 1'b0};
        vecs[3] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 10, 1'b0};
        vecs[4] = '{16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0,  0, 1'b1};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1,  0, 1'b0};
        vecs[6] = '{16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0,  3, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x         = '0;
        y         = '0;
        c_in      = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub       = 1'b0;
`endif
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", s, 0);
        chk("rst_c_out", c_out, 0);

        for (int i = 0; i < 7; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].es, vecs[i].ec,
                   vecs[i].stall, vecs[i].disturb);

        for (int k = 0; k < 6; k++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic         ci;
            logic [W:0]   m;
            a  = W'($urandom);
            b  = W'($urandom);
            ci = 1'($urandom_range(0, 1));
            m  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
            run_op(a, b, ci, m[W-1:0], m[W], 0, 1'b0);
        end

        // Reset during the second RUN cycle aborts the operation.
        x        = 16'h1111;
        y        = 16'h2222;
        c_in     = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_sum", s, 0);
        chk("abort_c_out", c_out, 0);
        saw_valid = 1'b0;
        repeat (6) begin
            tick();
            if (out_valid) saw_valid = 1'b1;
        end
        chk("abort_no_valid", saw_valid, 0);

        // Reset wins over a simultaneous in_valid.
        rst      = 1'b1;
        in_valid = 1'b1;
        x        = 16'h0F0F;
        y        = 16'h0101;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_vs_valid_in_ready", in_ready, 1);
        saw_valid = 1'b0;
        repeat (6) begin
            tick();
            if (out_valid || !in_ready) saw_valid = 1'b1;
        end
        chk("rst_vs_valid_no_op", saw_valid, 0);

        run_op(16'h0100, 16'h0200, 1'b0, 16'h0300, 1'b0, 0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b1;
        run_op(16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 0, 1'b0);
        run_op(16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1, 0, 1'b0);
        sub = 1'b0;
        run_op(16'h0007, 16'h0005, 1'b0, 16'h000C, 1'b0, 0, 1'b0);
`endif

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Multi-cycle controller that computes a WIDTH-bit sum using a single shared 4-bit adder slice, one nibble per cycle, least-significant nibble first. A registered carry links the nibbles. Valid/ready handshakes on both sides let the block sit between a producer and a consumer in the datapath. It trades latency for area against a fully combinational WIDTH-bit adder.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 8.
STEPS, WIDTH/4, derived local constant; number of slice iterations; not overridable.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands on x/y/c_in are valid
in_ready  output  1  controller can accept a new operation
x  input  WIDTH  operand A
y  input  WIDTH  operand B
c_in  input  1  initial carry into nibble 0
out_valid  output  1  s/c_out hold a completed result
out_ready  input  1  consumer accepts the result
s  output  WIDTH  sum, modulo 2^WIDTH
c_out  output  1  carry out of bit WIDTH-1

Behaviour:
- Clock/reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, s=0, c_out=0, step counter=0, carry register=0.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch x, y and c_in into operand registers, set counter=0 and carry=c_in, then go to RUN.
  - RUN: in_ready=0. Each cycle, the slice adds nibble[counter] of x and y plus carry. Write the 4-bit result into s[4*counter+3:4*counter]. The carry register takes bit 4 of the 5-bit slice sum. Increment counter. After processing counter==STEPS-1, go to DONE.
  - DONE: out_valid=1, c_out=final carry, in_ready=0. On out_ready, go to IDLE and drop out_valid.
- Latency: accept at edge N; out_valid rises after edge N+STEPS (STEPS cycles in RUN). Example: WIDTH=16 gives 4 cycles.
- Throughput: one operation per STEPS+2 cycles at best, since there is no accept in the same cycle as DONE→IDLE.
- Output stability: s and c_out stay stable while out_valid=1 and out_ready=0, for any stall length.
- s is written nibble-by-nibble during RUN; it is meaningful only while out_valid=1.
- Inputs: x/y/c_in and in_valid are ignored outside IDLE. Operand registers isolate the computation from input changes.
- Carry arithmetic: the carry is exactly the 5th bit of (nibble_x + nibble_y + carry), never a magnitude compare. A sum of exactly 16 produces carry=1.
- Reset in RUN or DONE: the operation is discarded and the block returns to IDLE the next cycle with reset values. No out_valid pulse is emitted.
- Simultaneous rst and in_valid: rst wins; nothing is accepted.

Optional Feature:
Macro SERIAL_ADDER_SUB_EN.
- Defined: adds input port sub (1 bit), latched with the operands. When sub=1, y is inverted at latch time and the initial carry is c_in^1. The result is then x - y (with c_in=0), and c_out=1 means no borrow. sub=0 behaves as plain addition.
- Undefined: no sub port; addition only.

Decomposition:
- Package serial_adder_pkg:
  - state enum {IDLE, RUN, DONE}
  - localparam SLICE_W=4
  - counter width function clog2(STEPS)
- One sub-module, adder_slice4: purely combinational; inputs a[3:0], b[3:0], ci; outputs sum[3:0], co, taken from a 5-bit add. The controller instantiates exactly one.

Test Plan:
- x=16'h1234, y=16'h4321, c_in=0, out_ready=1 → out_valid exactly 4 cycles after accept; s=16'h5555, c_out=0; in_ready low for 5 cycles.
- x=16'hFFFF, y=16'h0001, c_in=0 → s=16'h0000, c_out=1 (carry ripples through all 4 nibbles). Also x=16'h000F, y=16'h0001 → s=16'h0010 (nibble sum exactly 16).
- x=16'h8000, y=16'h8000, c_in=1 → s=16'h0001, c_out=1. Hold out_ready=0 for 10 cycles: out_valid, s and c_out stay stable and in_ready=0. Raise out_ready → IDLE next cycle.
- Change x/y and pulse in_valid during RUN → result still reflects the originally latched operands; no second operation starts.
- Assert rst for 1 cycle in the 2nd RUN cycle → next cycle shows IDLE, in_ready=1, out_valid=0, s=0. A following op, 16'h0100+16'h0200, gives 16'h0300.
- With SERIAL_ADDER_SUB_EN: x=16'h0005, y=16'h0007, sub=1, c_in=0 → s=16'hFFFE, c_out=0. Then x=16'h0007, y=16'h0005 → s=16'h0002, c_out=1.
